// File: rtl/arb2_rr.sv
// arb2_rr: two-source round-robin arbiter with a single registered output slot.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   A_VALID/A_DATA/A_READY   source A handshake and payload
//   B_VALID/B_DATA/B_READY   source B handshake and payload
//   OUT_VALID/OUT_DATA/OUT_READY  registered output handshake and payload
//   SEL                 registered source of OUT_DATA (0 = A, 1 = B)
//   CNT_A, CNT_B        saturating per-source grant counters
//
// The output slot accepts a new word while the held one drains, so with
// OUT_READY high the arbiter sustains one word per cycle. READY outputs depend
// only on VALIDs, OUT_READY, reset and registered state, never on payload.
module arb2_rr #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 A_VALID,
  input  logic [WIDTH-1:0]     A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [WIDTH-1:0]     B_DATA,
  output logic                 B_READY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  input  logic                 OUT_READY,
  output logic                 SEL,
  output logic [CNT_WIDTH-1:0] CNT_A,
  output logic [CNT_WIDTH-1:0] CNT_B
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 sel_q, sel_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_WIDTH-1:0] cnt_b_q, cnt_b_d;

  logic slot_free;
  logic grant_a;
  logic grant_b;
  logic xfer_a;
  logic xfer_b;

  always_comb begin
    slot_free = (state_q == EMPTY) || OUT_READY;
    // On a tie the source that was not granted last wins; last_q = 1 means B.
    grant_a   = A_VALID && (!B_VALID || last_q);
    grant_b   = B_VALID && (!A_VALID || !last_q);
    xfer_a    = !RST && slot_free && grant_a;
    xfer_b    = !RST && slot_free && grant_b;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;

    if (xfer_a) begin
      state_d    = FULL;
      last_d     = 1'b0;
      sel_d      = 1'b0;
      out_data_d = A_DATA;
      if (cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
    end else if (xfer_b) begin
      state_d    = FULL;
      last_d     = 1'b1;
      sel_d      = 1'b1;
      out_data_d = B_DATA;
      if (cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
    end else if (state_q == FULL && OUT_READY) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      out_data_q <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      out_data_q <= out_data_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

  assign A_READY   = xfer_a;
  assign B_READY   = xfer_b;
  assign OUT_VALID = (state_q == FULL);
  assign OUT_DATA  = out_data_q;
  assign SEL       = sel_q;
  assign CNT_A     = cnt_a_q;
  assign CNT_B     = cnt_b_q;

endmodule

// File: tb/tb_arb2_rr.sv
// tb_arb2_rr: directed bench for arb2_rr. Two instances share all inputs:
// dut uses the default counter width, dut2 uses CNT_WIDTH=2 so counter
// saturation shows up after a handful of grants.
module tb_arb2_rr;

  logic       CLK = 1'b0;
  logic       RST;
  logic       A_VALID, B_VALID, OUT_READY;
  logic [7:0] A_DATA, B_DATA;

  logic       a_ready, b_ready, out_valid, sel;
  logic [7:0] out_data, cnt_a, cnt_b;
  logic       a_ready2, b_ready2, out_valid2, sel2;
  logic [7:0] out_data2;
  logic [1:0] cnt_a2, cnt_b2;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  arb2_rr dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(a_ready),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(b_ready),
    .OUT_VALID(out_valid), .OUT_DATA(out_data), .OUT_READY(OUT_READY),
    .SEL(sel), .CNT_A(cnt_a), .CNT_B(cnt_b)
  );

  arb2_rr #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(a_ready2),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(b_ready2),
    .OUT_VALID(out_valid2), .OUT_DATA(out_data2), .OUT_READY(OUT_READY),
    .SEL(sel2), .CNT_A(cnt_a2), .CNT_B(cnt_b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; A_VALID = 1'b1; B_VALID = 1'b1; OUT_READY = 1'b1;
    A_DATA = 8'h00; B_DATA = 8'h00;
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);

    // Continuous tie with free output: A,B,A,B with no bubbles.
    RST = 1'b0; A_DATA = 8'h11; B_DATA = 8'h22;
    #1;
    chk("tie0_a_ready", a_ready, 1);
    chk("tie0_b_ready", b_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_out_valid", out_valid, 1);
      chk("alt_out_data", out_data, (i % 2 == 0) ? 32'h11 : 32'h22);
      chk("alt_sel", sel, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    chk("alt_cnt_a", cnt_a, 2);
    chk("alt_cnt_b", cnt_b, 2);

    // B alone three times; B stays last, so the following tie goes to A.
    A_VALID = 1'b0; B_DATA = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bonly_out_data", out_data, 32'h33);
      chk("bonly_sel", sel, 1);
    end
    chk("bonly_cnt_b", cnt_b, 5);
    A_VALID = 1'b1; A_DATA = 8'h44;
    #1;
    chk("tie1_a_ready", a_ready, 1);
    chk("tie1_b_ready", b_ready, 0);
    tick();
    chk("tie1_out_data", out_data, 32'h44);
    chk("tie1_sel", sel, 0);
    chk("tie1_cnt_a", cnt_a, 3);

    // Stall: output held stable while A waits.
    B_VALID = 1'b0; OUT_READY = 1'b0; A_DATA = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_a_ready", a_ready, 0);
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 32'h44);
      chk("stall_sel", sel, 0);
    end
    OUT_READY = 1'b1;
    #1;
    chk("drain_a_ready", a_ready, 1);
    tick();
    chk("drain_out_valid", out_valid, 1);
    chk("drain_out_data", out_data, 32'h5A);
    chk("drain_cnt_a", cnt_a, 4);

    // Reset while FULL discards the word; the next tie grants A.
    RST = 1'b1; B_VALID = 1'b1;
    #1;
    chk("rst2_a_ready", a_ready, 0);
    chk("rst2_b_ready", b_ready, 0);
    tick();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_sel", sel, 0);
    chk("rst2_cnt_a", cnt_a, 0);
    chk("rst2_cnt_b", cnt_b, 0);
    chk("rst2_cnt_a2", cnt_a2, 0);
    RST = 1'b0;
    #1;
    chk("tie2_a_ready", a_ready, 1);
    chk("tie2_b_ready", b_ready, 0);

    // Five consecutive A grants: the 2-bit counter saturates at 3.
    B_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      A_DATA = 8'h60 + 8'(i);
      tick();
      chk("sat_out_data", out_data, 32'h60 + i);
      chk("sat_cnt_a", cnt_a, i + 1);
      chk("sat_cnt_a2", cnt_a2, (i < 2) ? i + 1 : 3);
    end

    // After A-only grants A is last, so a tie now goes to B.
    B_VALID = 1'b1;
    #1;
    chk("tie3_a_ready", a_ready, 0);
    chk("tie3_b_ready", b_ready, 1);

    // No requests: slot drains to EMPTY, payload and SEL hold.
    A_VALID = 1'b0; B_VALID = 1'b0;
    tick();
    chk("empty_out_valid", out_valid, 0);
    chk("empty_out_data", out_data, 32'h64);
    chk("empty_sel", sel, 0);
    OUT_READY = 1'b0;
    tick();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_data", out_data, 32'h64);
    OUT_READY = 1'b1;
    tick();
    chk("idle_rdy_out_valid", out_valid, 0);
    chk("idle_cnt_a", cnt_a, 5);
    chk("idle_cnt_b", cnt_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arb2_rr.md
ARB2_RR -- requirements
Module: arb2_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width of each source and of the output.
REQ-002 Parameter CNT_WIDTH, default 8, width of each per-source grant counter.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-005 A_VALID  input  1  source A offers A_DATA this cycle.
REQ-006 A_DATA  input  WIDTH  source A payload.
REQ-007 A_READY  output  1  source A transfer occurs this cycle when A_VALID & A_READY.
REQ-008 B_VALID  input  1  source B offers B_DATA this cycle.
REQ-009 B_DATA  input  WIDTH  source B payload.
REQ-010 B_READY  output  1  source B transfer occurs this cycle when B_VALID & B_READY.
REQ-011 OUT_VALID  output  1  OUT_DATA holds a granted word.
REQ-012 OUT_DATA  output  WIDTH  registered payload of the last granted source.
REQ-013 OUT_READY  input  1  consumer accepts OUT_DATA when OUT_VALID & OUT_READY.
REQ-014 SEL  output  1  registered source of OUT_DATA (0 = A, 1 = B); drives a downstream 2:1 mux select.
REQ-015 CNT_A  output  CNT_WIDTH  number of A grants since reset, saturating.
REQ-016 CNT_B  output  CNT_WIDTH  number of B grants since reset, saturating.

Function
REQ-017 Two-state FSM: EMPTY (OUT_VALID=0), FULL (OUT_VALID=1); OUT_VALID shall equal (state == FULL).
REQ-018 Slot free this cycle: state EMPTY, or state FULL with OUT_READY=1 (accept-while-drain).
REQ-019 Arbitration, combinational on current inputs: only A_VALID -> grant A; only B_VALID -> grant B; both -> grant the source not equal to LAST; neither -> no grant.
REQ-020 A_READY = slot free & grant A; B_READY = slot free & grant B; never both high in one cycle.
REQ-021 A_READY/B_READY depend on A_VALID/B_VALID and OUT_READY only; no combinational path from any *_DATA to any output.
REQ-022 On a transfer: OUT_DATA <= granted data, SEL <= granted source, LAST <= granted source, state <= FULL, granted counter +1.
REQ-023 Latency: word accepted in cycle n appears on OUT_DATA with OUT_VALID=1 in cycle n+1.
REQ-024 FULL & OUT_READY=1 & no transfer -> EMPTY; FULL & OUT_READY=0 -> stay FULL, OUT_DATA and SEL held stable.
REQ-025 EMPTY & no transfer -> stay EMPTY; OUT_DATA and SEL hold last values.
REQ-026 Back-to-back: with OUT_READY=1 and both sources valid continuously, grants alternate A,B,A,B..., one word per cycle, no bubbles.
REQ-027 LAST changes only on a transfer; a single requester never loses priority because of the other's absence.
REQ-028 Counters saturate at 2^CNT_WIDTH-1; no wrap to 0.
REQ-029 OUT_READY without OUT_VALID has no effect.

Reset
REQ-030 RST=1 at a rising edge sets state EMPTY, OUT_VALID=0, OUT_DATA=0, SEL=0, LAST=1, CNT_A=0, CNT_B=0.
REQ-031 While RST=1, A_READY=0 and B_READY=0; no transfer counted.
REQ-032 RST asserted while FULL discards the held word; first post-reset tie grants A.

Verification
REQ-033 Reset, then A_VALID=B_VALID=1, A_DATA=0x11, B_DATA=0x22, OUT_READY=1 for 4 cycles -> OUT_DATA 0x11,0x22,0x11,0x22 on cycles 1-4, SEL 0,1,0,1, CNT_A=CNT_B=2.
REQ-034 Only B_VALID=1 for 3 cycles, OUT_READY=1 -> three B grants, SEL=1, then a tie grants A.
REQ-035 A word in FULL, OUT_READY=0 for 5 cycles with A_VALID=1 -> A_READY=0, OUT_DATA and SEL stable; OUT_READY=1 -> held word drained and new A word loaded same cycle.
REQ-036 CNT_WIDTH=2, 5 consecutive A grants -> CNT_A=3 after third grant, stays 3.
REQ-037 RST pulsed while FULL with OUT_DATA=0x5A -> next cycle OUT_VALID=0, OUT_DATA=0, SEL=0, counters 0; subsequent tie grants A.
